// File: rtl/uart_string_rx.sv
// uart_string_rx
// 8N1 UART receiver that writes each good byte into a 2^ADDR_W-byte string
// buffer at an incrementing address. A received 0x00 ends the string: it
// pulses done_o together with the write and rewinds the write pointer.
//
// Ports:
//   clk_i        system clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   line_i       asynchronous serial input, idle high
//   data_o       received byte, valid while we_o=1 (held until next write)
//   addr_o       buffer write address, valid while we_o=1 (held until next write)
//   we_o         one-cycle write strobe per good byte
//   done_o       one-cycle pulse with we_o when the byte written is 0x00
//   frame_err_o  one-cycle pulse when the stop bit is sampled low
//   overflow_o   one-cycle pulse when a non-null byte lands on the last address
//   busy_o       high from start-bit detect until the frame ends
module uart_string_rx #(
  parameter int CLKS_PER_BIT = 208,
  parameter int ADDR_W       = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              line_i,
  output logic [7:0]        data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic              done_o,
  output logic              frame_err_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        data_d;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d, done_d, ferr_d, ovf_d, busy_d;

  // Synchronizer stage: rx_p0 -> rx_p1, both reset to idle-high
  logic rx_p0, rx_p1;
  logic rx;
  // Tracks whether rx_p1 already holds a real sample of line_i rather than
  // the reset value; without it a line held low through reset would look
  // high for two cycles after release and then be taken as a start bit.
  logic [1:0] sync_vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      sync_vld_q <= 2'b00;
    end else begin
      rx_p0      <= line_i;
      rx_p1      <= rx_p0;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  assign rx = rx_p1;

  // Frame FSM: next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    data_d  = data_o;
    addr_d  = addr_o;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovf_d   = 1'b0;
    busy_d  = busy_o;

    case (state_q)
      WAIT_IDLE: begin
        if (rx && sync_vld_q[1]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      IDLE: begin
        if (!rx) begin
          state_d = START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          if (rx) begin
            // Line went back high before mid start bit: glitch
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_FULL) begin
          shreg_d[bit_q] = rx;
          cnt_d          = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            we_d    = 1'b1;
            data_d  = shreg_q;
            addr_d  = ptr_q;
            if (shreg_q == 8'h00) begin
              done_d = 1'b1;
              ptr_d  = '0;
            end else if (ptr_q == PTR_LAST) begin
              ovf_d = 1'b1;
              ptr_d = '0;
            end else begin
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end else begin
            // Bad stop bit: drop the byte and wait for the line to recover;
            // busy stays high until it does.
            state_d = WAIT_IDLE;
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  // Register stage: state, counters, pointer and outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      ptr_q       <= '0;
      data_o      <= 8'h00;
      addr_o      <= '0;
      we_o        <= 1'b0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      ptr_q       <= ptr_d;
      data_o      <= data_d;
      addr_o      <= addr_d;
      we_o        <= we_d;
      done_o      <= done_d;
      frame_err_o <= ferr_d;
      overflow_o  <= ovf_d;
      busy_o      <= busy_d;
    end
  end

  // Shift register carries data only; every bit is rewritten before use
  always_ff @(posedge clk_i) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_uart_string_rx.sv
// Testbench for uart_string_rx: drives 8N1 frames on line_i and checks each
// write against a scoreboard of expected {data, addr, done, overflow}.
module tb_uart_string_rx;

  localparam int CPB = 16;
  localparam int AW  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          line_i;
  logic [7:0]    data_o;
  logic [AW-1:0] addr_o;
  logic          we_o, done_o, frame_err_o, overflow_o, busy_o;

  uart_string_rx #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .line_i     (line_i),
    .data_o     (data_o),
    .addr_o     (addr_o),
    .we_o       (we_o),
    .done_o     (done_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]    data;
    logic [AW-1:0] addr;
    logic          done;
    logic          ovf;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] mptr = '0;
  int            n_checks = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            t_start = 0;
  int            last_we_cyc = 0;
  int            ferr_cnt = 0;
  logic          prev_we = 1'b0;
  logic          prev_ferr = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_t e;
    e.data = b;
    e.addr = mptr;
    e.done = (b == 8'h00);
    e.ovf  = (b != 8'h00) && (mptr == {AW{1'b1}});
    exp_q.push_back(e);
    if (b == 8'h00 || mptr == {AW{1'b1}}) mptr = '0;
    else mptr = mptr + 1'b1;
  endtask

  // Entry and exit at posedge+1. good_stop=0 drives the stop bit low.
  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    logic [9:0] frame;
    frame = {good_stop, b, 1'b0};
    if (good_stop) push_exp(b);
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      line_i = frame[i];
      repeat (CPB) @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_data"}, data_o, 0);
    check_eq({pfx, "_addr"}, addr_o, 0);
    check_eq({pfx, "_we"}, we_o, 0);
    check_eq({pfx, "_done"}, done_o, 0);
    check_eq({pfx, "_ferr"}, frame_err_o, 0);
    check_eq({pfx, "_ovf"}, overflow_o, 0);
    check_eq({pfx, "_busy"}, busy_o, 0);
  endtask

  // Output monitor: pops the scoreboard on every write strobe
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (we_o) begin
        exp_t e;
        last_we_cyc = cyc;
        check_eq("we_consec", prev_we, 0);
        check_eq("ferr_with_we", frame_err_o, 0);
        check_eq("we_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("wr_data", data_o, e.data);
          check_eq("wr_addr", addr_o, e.addr);
          check_eq("wr_done", done_o, e.done);
          check_eq("wr_ovf", overflow_o, e.ovf);
        end
      end else begin
        if (done_o) check_eq("done_without_we", done_o, 0);
        if (overflow_o) check_eq("ovf_without_we", overflow_o, 0);
      end
      if (frame_err_o) begin
        ferr_cnt++;
        check_eq("ferr_consec", prev_ferr, 0);
      end
      prev_we   = we_o;
      prev_ferr = frame_err_o;
    end else begin
      prev_we   = 1'b0;
      prev_ferr = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line_i = 1'b1;
    rst_i  = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check_reset_outputs("rst");
    rst_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;

    // "Hi\0" back-to-back; the first frame also gives the start-to-write latency
    send_byte(8'h48, 1'b1);
    check_eq("latency", last_we_cyc - t_start, 155);
    send_byte(8'h69, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    check_eq("hi_drained", exp_q.size(), 0);

    // Short low glitch: busy rises, then drops at the start-bit sample
    line_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    line_i = 1'b1;
    check_eq("glitch_busy_hi", busy_o, 1);
    repeat (5) @(posedge clk_i);
    #1;
    check_eq("glitch_busy_before_sample", busy_o, 1);
    @(posedge clk_i);
    #1;
    check_eq("glitch_busy_dropped", busy_o, 0);
    repeat (10) @(posedge clk_i);
    #1;
    send_byte(8'h55, 1'b1);
    repeat (10) @(posedge clk_i);
    #1;
    check_eq("glitch_drained", exp_q.size(), 0);

    // Frame error with the line held low afterwards
    send_byte(8'hA5, 1'b0);
    repeat (40) @(posedge clk_i);
    #1;
    check_eq("ferr_count", ferr_cnt, 1);
    check_eq("ferr_busy_held", busy_o, 1);
    check_eq("ferr_data_hold", data_o, 8'h55);
    line_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    check_eq("ferr_busy_released", busy_o, 0);
    repeat (10) @(posedge clk_i);
    #1;
    send_byte(8'h3C, 1'b1);

    // Rewind, then 17 non-null bytes to wrap the pointer
    send_byte(8'h00, 1'b1);
    for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1);
    repeat (10) @(posedge clk_i);
    #1;
    check_eq("ovf_drained", exp_q.size(), 0);

    // Reset in the middle of DATA bit 4 with the line held low
    line_i = 1'b0;
    repeat (CPB * 5 + 8) @(posedge clk_i);
    #1;
    check_eq("pre_rst_busy", busy_o, 1);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    mptr  = '0;
    repeat (50) @(posedge clk_i);
    #1;
    check_eq("lowline_no_start", busy_o, 0);
    line_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    send_byte(8'h77, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    check_eq("final_drained", exp_q.size(), 0);
    check_eq("ferr_total", ferr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
